ppc_sequencer: RTL and testbench
================================

PPC_SEQUENCER -- requirements
Module: ppc_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: all state changes on rising edge of clk, and rst=1 sampled at a rising edge resets the block.
REQ-002 Parameter TICK_DIV, default 50_000_000, SHALL set the clk cycles per step in RUN; legal range 2..2^32-1.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 run_req  input  1  level; 1 = counter runs, 0 = paused.
REQ-006 flip_req  input  1  single-cycle request to reverse direction.
REQ-007 load_req  input  1  single-cycle request to load max_in/min_in.
REQ-008 max_in, min_in  input  4 each  candidate bounds.
REQ-009 step  output  1  single-cycle strobe: counter advances once.
REQ-010 flip_out  output  1  single-cycle strobe: counter toggles direction.
REQ-011 load_out  output  1  single-cycle strobe: counter reloads from min_out.
REQ-012 max_out, min_out  output  4 each  registered active bounds.
REQ-013 state  output  2  FSM state: 00 IDLE, 01 RUN, 10 LOAD.
REQ-014 cfg_err  output  1  last load_req was rejected.

Function
REQ-015 The FSM SHALL behave as follows:
- IDLE goes to RUN when run_req=1.
- RUN goes to IDLE when run_req=0.
- Either state goes to LOAD when a load request is accepted.
- LOAD lasts exactly 1 cycle, then goes to RUN if run_req=1, else IDLE.
REQ-016 Tick counter SHALL count 0..TICK_DIV-1 only in RUN, hold in LOAD, and clear to 0 on every entry to IDLE.
REQ-017 A step event SHALL be raised on the cycle the tick counter equals TICK_DIV-1, and the counter SHALL then wrap to 0.
REQ-018 Load acceptance: load_req with max_in > min_in SHALL be accepted, as follows:
- max_out/min_out register max_in/min_in at that edge.
- load_out=1 during the LOAD cycle.
- cfg_err clears.
REQ-019 Load rejection: load_req with max_in <= min_in SHALL be rejected, as follows:
- bounds unchanged.
- no LOAD state, no load_out.
- cfg_err=1 from the next cycle until the next accepted load.
REQ-020 At most one of step/flip_out/load_out SHALL be high per cycle, with priority load > flip > step.
REQ-021 Deferred events SHALL work as follows:
- A flip or step event that loses arbitration sets a one-deep pending flag.
- The pending flag is issued at the first cycle it wins, in priority order.
- Repeat requests while pending merge (no double issue).
REQ-022 Pending step SHALL be discarded on entry to IDLE or LOAD. Pending flip SHALL survive any state change except reset.
REQ-023 flip_req SHALL be serviced in any state, including IDLE.
REQ-024 Strobes SHALL be registered: a request at edge N produces its strobe during cycle N+1 when uncontested.
REQ-025 Arithmetic SHALL be unsigned. The tick counter is 32 bits, and max/min compare is 4-bit unsigned.

Reset
REQ-026 Reset SHALL set the outputs and internal state as follows:
- state=IDLE; tick counter=0; pending flags cleared.
- step=flip_out=load_out=0; cfg_err=0.
- max_out=4'd15, min_out=4'd0.
REQ-027 Reset asserted mid-LOAD or with pending events SHALL abort them, with no strobe in the cycle after reset.
REQ-028 Reset SHALL take priority over every request in the same cycle.

Configuration
REQ-029 With macro PPC_SEQ_SINGLE_STEP_EN defined, the block SHALL add input step_req (1 bit, single-cycle), as follows:
- In IDLE, step_req raises one step event, subject to REQ-020/021.
- In RUN or LOAD, step_req is ignored.
REQ-030 Without PPC_SEQ_SINGLE_STEP_EN, the step_req port SHALL be absent and IDLE SHALL never emit step.

Verification
REQ-031 TICK_DIV=4, reset, run_req=1 held 20 cycles -> step pulses every 4th cycle, first at cycle 4 after entering RUN; state=01.
REQ-032 IDLE, load_req with max_in=9, min_in=2 -> next cycle state=10, load_out=1, max_out=9, min_out=2; then state=00, cfg_err=0.
REQ-033 load_req with max_in=3, min_in=3 -> no load_out, bounds unchanged, cfg_err=1 until a valid load (max_in=5, min_in=1) clears it.
REQ-034 RUN, TICK_DIV=4, flip_req and load_req on the cycle step fires -> load_out cycle N+1, flip_out cycle N+2, step dropped; tick counter resumes counting from its held value in RUN.
REQ-035 run_req dropped mid-count (counter=2), then raised again -> tick restarts at 0 and the next step comes 4 cycles after re-entry.
REQ-036 PPC_SEQ_SINGLE_STEP_EN defined, IDLE, step_req pulse -> exactly one step next cycle. Same pulse in RUN -> no extra step.

Source files
------------

// File: rtl/ppc_sequencer_if.sv
// Request/strobe bundle between a controller (master) and ppc_sequencer (slave).
// step_req exists only when PPC_SEQ_SINGLE_STEP_EN is defined.
interface ppc_sequencer_if;
    logic       run_req;
    logic       flip_req;
    logic       load_req;
    logic [3:0] max_in;
    logic [3:0] min_in;
`ifdef PPC_SEQ_SINGLE_STEP_EN
    logic       step_req;
`endif
    logic       step;
    logic       flip_out;
    logic       load_out;
    logic [3:0] max_out;
    logic [3:0] min_out;
    logic [1:0] state;
    logic       cfg_err;

    modport master (
`ifdef PPC_SEQ_SINGLE_STEP_EN
        output step_req,
`endif
        output run_req, flip_req, load_req, max_in, min_in,
        input  step, flip_out, load_out, max_out, min_out, state, cfg_err
    );

    modport slave (
`ifdef PPC_SEQ_SINGLE_STEP_EN
        input  step_req,
`endif
        input  run_req, flip_req, load_req, max_in, min_in,
        output step, flip_out, load_out, max_out, min_out, state, cfg_err
    );
endinterface

// File: rtl/ppc_sequencer.sv
// Step/flip/load strobe sequencer: IDLE/RUN/LOAD FSM, tick divider, prioritised registered strobes.
// Optional macro PPC_SEQ_SINGLE_STEP_EN adds a manual step_req honoured only in IDLE.
module ppc_sequencer #(
    parameter logic [31:0] TICK_DIV = 32'd50_000_000
) (
    input  logic           clk,
    input  logic           rst,
    ppc_sequencer_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_LOAD = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [31:0] tick_q, tick_d;
    logic        flip_pend_q, flip_pend_d;
    logic        step_pend_q, step_pend_d;
    logic        step_q, step_d;
    logic        flip_q, flip_d;
    logic        load_q, load_d;
    logic        cfg_err_q, cfg_err_d;
    logic [3:0]  max_q, max_d;
    logic [3:0]  min_q, min_d;

    logic load_valid, load_ok, load_bad;
    logic tick_wrap, step_single, flip_ev, step_ev, step_drop;

    // Load requests are only considered outside the one-cycle LOAD state.
    assign load_valid = bus.load_req && (state_q != ST_LOAD);
    assign load_ok    = load_valid && (bus.max_in > bus.min_in);
    assign load_bad   = load_valid && !(bus.max_in > bus.min_in);
    assign tick_wrap  = (state_q == ST_RUN) && (tick_q == TICK_DIV - 32'd1);

`ifdef PPC_SEQ_SINGLE_STEP_EN
    assign step_single = bus.step_req && (state_q == ST_IDLE);
`else
    assign step_single = 1'b0;
`endif

    assign flip_ev = bus.flip_req || flip_pend_q;
    assign step_ev = tick_wrap || step_single || step_pend_q;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load_ok) state_d = ST_LOAD;
                     else if (bus.run_req) state_d = ST_RUN;
            ST_RUN:  if (load_ok) state_d = ST_LOAD;
                     else if (!bus.run_req) state_d = ST_IDLE;
            ST_LOAD: state_d = bus.run_req ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Step events (new or pending) die when the FSM enters IDLE or LOAD.
    assign step_drop = (state_d != state_q) && (state_d != ST_RUN);

    always_comb begin
        load_d      = load_ok;
        flip_d      = 1'b0;
        step_d      = 1'b0;
        flip_pend_d = flip_ev;
        step_pend_d = step_ev && !step_drop;
        if (load_ok) begin
            load_d = 1'b1;
        end else if (flip_ev) begin
            flip_d      = 1'b1;
            flip_pend_d = 1'b0;
        end else if (step_ev && !step_drop) begin
            step_d      = 1'b1;
            step_pend_d = 1'b0;
        end
    end

    always_comb begin
        tick_d = tick_q;
        if (state_d == ST_IDLE) begin
            tick_d = 32'd0;
        end else if (state_q == ST_RUN) begin
            tick_d = tick_wrap ? 32'd0 : tick_q + 32'd1;
        end
    end

    always_comb begin
        cfg_err_d = cfg_err_q;
        if (load_ok)       cfg_err_d = 1'b0;
        else if (load_bad) cfg_err_d = 1'b1;
        max_d = load_ok ? bus.max_in : max_q;
        min_d = load_ok ? bus.min_in : min_q;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tick_q      <= 32'd0;
            flip_pend_q <= 1'b0;
            step_pend_q <= 1'b0;
            step_q      <= 1'b0;
            flip_q      <= 1'b0;
            load_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            max_q       <= 4'd15;
            min_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            flip_pend_q <= flip_pend_d;
            step_pend_q <= step_pend_d;
            step_q      <= step_d;
            flip_q      <= flip_d;
            load_q      <= load_d;
            cfg_err_q   <= cfg_err_d;
            max_q       <= max_d;
            min_q       <= min_d;
        end
    end

    assign bus.step     = step_q;
    assign bus.flip_out = flip_q;
    assign bus.load_out = load_q;
    assign bus.max_out  = max_q;
    assign bus.min_out  = min_q;
    assign bus.state    = state_q;
    assign bus.cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_ppc_sequencer.sv
// Directed self-checking bench for ppc_sequencer with TICK_DIV=4.
// Exercises the manual step_req path too when PPC_SEQ_SINGLE_STEP_EN is defined.
module tb_ppc_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    ppc_sequencer_if bus ();

    ppc_sequencer #(.TICK_DIV(32'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
`ifdef PPC_SEQ_SINGLE_STEP_EN
        bus.step_req = 1'b0;
`endif
        // Reset beats every simultaneous request, including a rejectable load.
        bus.run_req  = 1'b1;
        bus.flip_req = 1'b1;
        bus.load_req = 1'b1;
        bus.max_in   = 4'd1;
        bus.min_in   = 4'd8;
        rst = 1'b1;
        cyc();
        cyc();
        check("rst_state",   32'(bus.state),    32'd0);
        check("rst_step",    32'(bus.step),     32'd0);
        check("rst_flip",    32'(bus.flip_out), 32'd0);
        check("rst_load",    32'(bus.load_out), 32'd0);
        check("rst_cfg_err", 32'(bus.cfg_err),  32'd0);
        check("rst_max",     32'(bus.max_out),  32'd15);
        check("rst_min",     32'(bus.min_out),  32'd0);

        rst = 1'b0;
        bus.run_req  = 1'b0;
        bus.flip_req = 1'b0;
        bus.load_req = 1'b0;
        cyc();
        check("post_rst_state", 32'(bus.state),    32'd0);
        check("post_rst_flip",  32'(bus.flip_out), 32'd0);

        // Free run: entry cycle is c0, steps at c4, c8, ... c20.
        bus.run_req = 1'b1;
        cyc();
        check("run_entry_state", 32'(bus.state), 32'd1);
        check("run_entry_step",  32'(bus.step),  32'd0);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            check($sformatf("run_step_c%0d", i), 32'(bus.step), (i % 4 == 0) ? 32'd1 : 32'd0);
        end
        check("run_state_end", 32'(bus.state), 32'd1);

        // Pause with tick=2, then resume: tick restarts at 0.
        cyc();
        cyc();
        bus.run_req = 1'b0;
        cyc();
        check("pause_state", 32'(bus.state), 32'd0);
        check("pause_step",  32'(bus.step),  32'd0);
        cyc();
        bus.run_req = 1'b1;
        cyc();
        check("resume_state", 32'(bus.state), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check($sformatf("resume_step_c%0d", i), 32'(bus.step), (i == 4) ? 32'd1 : 32'd0);
        end
        bus.run_req = 1'b0;
        cyc();
        check("idle_again", 32'(bus.state), 32'd0);

        // Accepted load from IDLE.
        bus.load_req = 1'b1;
        bus.max_in   = 4'd9;
        bus.min_in   = 4'd2;
        cyc();
        check("load9_state", 32'(bus.state),    32'd2);
        check("load9_out",   32'(bus.load_out), 32'd1);
        check("load9_max",   32'(bus.max_out),  32'd9);
        check("load9_min",   32'(bus.min_out),  32'd2);
        bus.load_req = 1'b0;
        cyc();
        check("load9_after_state", 32'(bus.state),    32'd0);
        check("load9_after_out",   32'(bus.load_out), 32'd0);
        check("load9_cfg_err",     32'(bus.cfg_err),  32'd0);

        // Rejected loads: equal bounds, then max < min.
        bus.load_req = 1'b1;
        bus.max_in   = 4'd3;
        bus.min_in   = 4'd3;
        cyc();
        check("rej_eq_load",  32'(bus.load_out), 32'd0);
        check("rej_eq_state", 32'(bus.state),    32'd0);
        check("rej_eq_max",   32'(bus.max_out),  32'd9);
        check("rej_eq_min",   32'(bus.min_out),  32'd2);
        check("rej_eq_err",   32'(bus.cfg_err),  32'd1);
        bus.load_req = 1'b0;
        cyc();
        check("rej_err_held", 32'(bus.cfg_err), 32'd1);
        bus.load_req = 1'b1;
        bus.max_in   = 4'd2;
        bus.min_in   = 4'd3;
        cyc();
        check("rej_lt_load", 32'(bus.load_out), 32'd0);
        check("rej_lt_max",  32'(bus.max_out),  32'd9);
        check("rej_lt_err",  32'(bus.cfg_err),  32'd1);
        bus.max_in = 4'd5;
        bus.min_in = 4'd1;
        cyc();
        check("fix_state", 32'(bus.state),    32'd2);
        check("fix_load",  32'(bus.load_out), 32'd1);
        check("fix_max",   32'(bus.max_out),  32'd5);
        check("fix_min",   32'(bus.min_out),  32'd1);
        check("fix_err",   32'(bus.cfg_err),  32'd0);
        bus.load_req = 1'b0;
        cyc();
        check("fix_after_state", 32'(bus.state), 32'd0);

        // Flip serviced in IDLE.
        bus.flip_req = 1'b1;
        cyc();
        check("idle_flip",       32'(bus.flip_out), 32'd1);
        check("idle_flip_state", 32'(bus.state),    32'd0);
        check("idle_flip_step",  32'(bus.step),     32'd0);
        bus.flip_req = 1'b0;
        cyc();
        check("idle_flip_off", 32'(bus.flip_out), 32'd0);

        // Load + flip on the step cycle: load, then flip, step dropped.
        bus.run_req = 1'b1;
        cyc();
        check("arb_run", 32'(bus.state), 32'd1);
        cyc();
        cyc();
        cyc();
        bus.flip_req = 1'b1;
        bus.load_req = 1'b1;
        bus.max_in   = 4'd12;
        bus.min_in   = 4'd4;
        cyc();
        check("arb_n1_state", 32'(bus.state),    32'd2);
        check("arb_n1_load",  32'(bus.load_out), 32'd1);
        check("arb_n1_flip",  32'(bus.flip_out), 32'd0);
        check("arb_n1_step",  32'(bus.step),     32'd0);
        check("arb_n1_max",   32'(bus.max_out),  32'd12);
        check("arb_n1_min",   32'(bus.min_out),  32'd4);
        bus.load_req = 1'b0;
        cyc();
        check("arb_n2_state", 32'(bus.state),    32'd1);
        check("arb_n2_flip",  32'(bus.flip_out), 32'd1);
        check("arb_n2_load",  32'(bus.load_out), 32'd0);
        check("arb_n2_step",  32'(bus.step),     32'd0);
        bus.flip_req = 1'b0;
        cyc();
        check("arb_n3_flip_merged", 32'(bus.flip_out), 32'd0);
        check("arb_n3_step",        32'(bus.step),     32'd0);
        cyc();
        check("arb_n4_step", 32'(bus.step), 32'd0);
        cyc();
        check("arb_n5_step", 32'(bus.step), 32'd0);
        cyc();
        check("arb_n6_step", 32'(bus.step), 32'd1);

        // Flip beats step; deferred step follows once.
        cyc();
        cyc();
        cyc();
        bus.flip_req = 1'b1;
        cyc();
        check("fs_flip", 32'(bus.flip_out), 32'd1);
        check("fs_step", 32'(bus.step),     32'd0);
        bus.flip_req = 1'b0;
        cyc();
        check("fs_pend_step", 32'(bus.step),     32'd1);
        check("fs_pend_flip", 32'(bus.flip_out), 32'd0);
        cyc();
        check("fs_no_double", 32'(bus.step), 32'd0);

        // Reset during LOAD with a pending flip aborts both.
        bus.run_req = 1'b0;
        cyc();
        check("abort_idle", 32'(bus.state), 32'd0);
        bus.load_req = 1'b1;
        bus.flip_req = 1'b1;
        bus.max_in   = 4'd6;
        bus.min_in   = 4'd5;
        cyc();
        check("abort_in_load", 32'(bus.state),    32'd2);
        check("abort_load_on", 32'(bus.load_out), 32'd1);
        bus.load_req = 1'b0;
        bus.flip_req = 1'b0;
        rst = 1'b1;
        cyc();
        check("abort_state", 32'(bus.state),    32'd0);
        check("abort_load",  32'(bus.load_out), 32'd0);
        check("abort_flip",  32'(bus.flip_out), 32'd0);
        check("abort_max",   32'(bus.max_out),  32'd15);
        rst = 1'b0;
        cyc();
        check("abort_after_flip", 32'(bus.flip_out), 32'd0);
        check("abort_after_step", 32'(bus.step),     32'd0);

`ifdef PPC_SEQ_SINGLE_STEP_EN
        // Manual step in IDLE, ignored in RUN.
        bus.step_req = 1'b1;
        cyc();
        check("ss_idle_step",  32'(bus.step),  32'd1);
        check("ss_idle_state", 32'(bus.state), 32'd0);
        bus.step_req = 1'b0;
        cyc();
        check("ss_idle_once", 32'(bus.step), 32'd0);
        bus.run_req = 1'b1;
        cyc();
        cyc();
        bus.step_req = 1'b1;
        cyc();
        check("ss_run_c2", 32'(bus.step), 32'd0);
        bus.step_req = 1'b0;
        cyc();
        check("ss_run_c3", 32'(bus.step), 32'd0);
        cyc();
        check("ss_run_c4", 32'(bus.step), 32'd1);
        bus.run_req = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
